// File: rtl/mc10_vram_pkg.sv
// Shared constants and types for the MC-10 video/system RAM time-slot arbiter.
package mc10_vram_pkg;

    // The 2-bit slot counter walks these four phases and then wraps.
    localparam logic [1:0] PH_SLOT_A = 2'd0;  // VDG slot, or donated to the CPU while blanked
    localparam logic [1:0] PH_CAP_A  = 2'd1;  // capture the read data of slot A
    localparam logic [1:0] PH_SLOT_B = 2'd2;  // CPU slot
    localparam logic [1:0] PH_CAP_B  = 2'd3;  // capture the read data of slot B

    // Which client was given the most recent RAM slot.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        VDG  = 2'd1,
        CPU  = 2'd2
    } owner_e;

    localparam int          RAM_AW_DEF   = 14;
    localparam logic [13:0] VID_BASE_DEF = 14'h0000;

endpackage

// File: rtl/mc10_vram_arbiter.sv
// Four-phase time-slot arbiter sharing the single-port RAM between the VDG
// fetch path and the 6803 CPU bus. Slot A feeds the VDG unless it is blanked,
// in which case the CPU may use it. Slot B always belongs to the CPU.
module mc10_vram_arbiter
    import mc10_vram_pkg::*;
#(
    parameter int                RAM_AW   = RAM_AW_DEF,
    parameter logic [RAM_AW-1:0] VID_BASE = RAM_AW'(VID_BASE_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [12:0]       vdg_addr,
    input  logic              vid_blank,
    output logic [7:0]        vdg_data,
    output logic              vdg_strobe,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    logic [1:0]        phase_q, phase_d;
    logic              pending_q, pending_d;
    logic              we_q, we_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    owner_e            owner_q, owner_d;
    logic              ack_q, ack_d;
    logic              strobe_q, strobe_d;
    logic [7:0]        vdg_data_q, vdg_data_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [12:0]       vaddr_q;
    logic              blank_q;

    // VDG inputs are plain pipeline registers; they keep sampling through reset
    // so the first slot after release already sees the current video address.
    always_ff @(posedge clk) begin
        vaddr_q <= vdg_addr;
        blank_q <= vid_blank;
    end

    // Arbiter state; reset aborts any access that is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= PH_SLOT_A;
            pending_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            owner_q     <= NONE;
            ack_q       <= 1'b0;
            strobe_q    <= 1'b0;
            vdg_data_q  <= 8'h00;
            cpu_rdata_q <= 8'h00;
        end else begin
            phase_q     <= phase_d;
            pending_q   <= pending_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            ack_q       <= ack_d;
            strobe_q    <= strobe_d;
            vdg_data_q  <= vdg_data_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    // Slot decode, CPU request capture and read-data capture.
    always_comb begin
        phase_d     = phase_q + 2'd1;
        pending_d   = pending_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = NONE;
        ack_d       = 1'b0;
        strobe_d    = 1'b0;
        vdg_data_d  = vdg_data_q;
        cpu_rdata_d = cpu_rdata_q;

        // A request is taken only when nothing is outstanding and the previous
        // ack has been seen, so a req still high in its ack cycle is ignored.
        if (!pending_q && !ack_q && cpu_req) begin
            pending_d = 1'b1;
            we_d      = cpu_we;
            addr_d    = cpu_addr;
            wdata_d   = cpu_wdata;
        end

        case (phase_q)
            PH_SLOT_A: begin
                if (!blank_q)      owner_d = VDG;
                else if (pending_q) owner_d = CPU;
            end
            PH_SLOT_B: begin
                if (pending_q) owner_d = CPU;
            end
            default: begin
                // Capture phases: RAM data from the previous slot is now valid.
                if (owner_q == VDG) begin
                    vdg_data_d = ram_rdata;
                    strobe_d   = 1'b1;
                end else if (owner_q == CPU) begin
                    if (!we_q) cpu_rdata_d = ram_rdata;
                    pending_d = 1'b0;
                    ack_d     = 1'b1;
                end
            end
        endcase
    end

    // RAM port driven only from registered state; held at zero during reset.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        if (!reset) begin
            if (owner_d == VDG) begin
                ram_addr = VID_BASE + RAM_AW'(vaddr_q);
            end else if (owner_d == CPU) begin
                ram_addr  = addr_q;
                ram_we    = we_q;
                ram_wdata = wdata_q;
            end
        end
    end

    assign vdg_data   = vdg_data_q;
    assign vdg_strobe = strobe_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ack    = ack_q;

endmodule

// File: tb/tb_mc10_vram_arbiter.sv
// Directed bench for mc10_vram_arbiter: reset abort, VDG cadence, CPU best and
// worst case latency, blank donation, handshake abuse and VDG address wrap.
module tb_mc10_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] vdg_addr;
    logic        vid_blank;
    logic [7:0]  vdg_data;
    logic        vdg_strobe;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        init;

    // second instance only for the VID_BASE wrap check
    logic [12:0] w_vaddr = 13'h0200;
    logic        w_zero  = 1'b0;
    logic [13:0] w_caddr = 14'h0000;
    logic [7:0]  w_byte  = 8'h00;
    logic [7:0]  w_vdata, w_crdata, w_wdata;
    logic        w_strobe, w_ack, w_we;
    logic [13:0] w_ram_addr;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [7:0] mem [0:16383];

    always #5 clk = ~clk;

    mc10_vram_arbiter u_dut (
        .clk(clk), .reset(reset),
        .vdg_addr(vdg_addr), .vid_blank(vid_blank),
        .vdg_data(vdg_data), .vdg_strobe(vdg_strobe),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    mc10_vram_arbiter #(.RAM_AW(14), .VID_BASE(14'h3F00)) u_wrap (
        .clk(clk), .reset(reset),
        .vdg_addr(w_vaddr), .vid_blank(w_zero),
        .vdg_data(w_vdata), .vdg_strobe(w_strobe),
        .cpu_req(w_zero), .cpu_we(w_zero), .cpu_addr(w_caddr),
        .cpu_wdata(w_byte), .cpu_rdata(w_crdata), .cpu_ack(w_ack),
        .ram_addr(w_ram_addr), .ram_we(w_we), .ram_wdata(w_wdata),
        .ram_rdata(w_byte)
    );

    // synchronous RAM, one-cycle read latency, preloaded while init is high
    always @(posedge clk) begin
        if (init) begin
            mem[14'h0123] <= 8'h5A;
            mem[14'h1000] <= 8'hC3;
            mem[14'h0300] <= 8'h11;
            mem[14'h0200] <= 8'h00;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // advance to the middle of the next cycle
    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(input int c);
        while (cyc < c) step();
    endtask

    task automatic req(input logic we, input logic [13:0] a, input logic [7:0] d);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    initial begin
        reset = 1'b1; init = 1'b1;
        vdg_addr = 13'h0123; vid_blank = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        step(); step();
        init = 1'b0;
        step();
        chk("rst_vdg_data",  vdg_data, 8'h00);
        chk("rst_strobe",    vdg_strobe, 1'b0);
        chk("rst_ack",       cpu_ack, 1'b0);
        chk("rst_rdata",     cpu_rdata, 8'h00);
        chk("rst_ram_we",    ram_we, 1'b0);
        chk("rst_ram_addr",  ram_addr, 14'h0000);
        chk("rst_ram_wdata", ram_wdata, 8'h00);

        // first run: issue a CPU write, then reset in the middle of its slot
        reset = 1'b0; cyc = 0;
        req(1'b1, 14'h0300, 8'hEE);
        go(2);
        chk("wr_issue_we",   ram_we, 1'b1);
        chk("wr_issue_addr", ram_addr, 14'h0300);
        reset = 1'b1; cpu_req = 1'b0;
        #1;
        chk("rst_mid_we", ram_we, 1'b0);
        step(); step();
        chk("rst_hold_we",  ram_we, 1'b0);
        chk("rst_hold_ack", cpu_ack, 1'b0);

        // second run: VDG cadence from 0x0123
        reset = 1'b0; cyc = 0;
        #1;
        chk("ph0_vdg_addr", ram_addr, 14'h0123);
        chk("ph0_we",       ram_we, 1'b0);
        chk("wrap_addr0",   w_ram_addr, 14'h0100);
        go(1); chk("c1_strobe", vdg_strobe, 1'b0);
        go(2); chk("c2_strobe", vdg_strobe, 1'b1); chk("c2_vdata", vdg_data, 8'h5A);
        go(3); chk("c3_strobe", vdg_strobe, 1'b0);
        go(4); chk("wrap_addr4", w_ram_addr, 14'h0100);
        go(6); chk("c6_strobe", vdg_strobe, 1'b1); chk("c6_vdata", vdg_data, 8'h5A);

        // CPU read, best case: captured at end of phase 1
        go(9);  req(1'b0, 14'h1000, 8'h00);
        go(10); chk("rd_addr", ram_addr, 14'h1000); chk("rd_cad_strobe", vdg_strobe, 1'b1);
        go(11); chk("rd_ack_early", cpu_ack, 1'b0);
        go(12); chk("rd_ack", cpu_ack, 1'b1); chk("rd_data", cpu_rdata, 8'hC3);
        cpu_req = 1'b0;
        go(13); chk("rd_ack_pulse", cpu_ack, 1'b0);
        go(14); chk("c14_strobe", vdg_strobe, 1'b1); chk("c14_vdata", vdg_data, 8'h5A);

        // CPU write, worst case: captured at end of phase 2, unblanked
        req(1'b1, 14'h0200, 8'h77);
        go(16); chk("wr_ph0_we", ram_we, 1'b0); chk("wr_ph0_addr", ram_addr, 14'h0123);
        go(17); chk("wr_ph1_we", ram_we, 1'b0);
        go(18); chk("wr_we", ram_we, 1'b1); chk("wr_addr", ram_addr, 14'h0200);
        chk("wr_wdata", ram_wdata, 8'h77);
        go(19); chk("wr_we_off", ram_we, 1'b0); chk("wr_ack_early", cpu_ack, 1'b0);
        go(20); chk("wr_ack", cpu_ack, 1'b1); chk("wr_rdata_keep", cpu_rdata, 8'hC3);
        cpu_req = 1'b0;
        vdg_addr = 13'h0200;
        go(22); chk("c22_vdata", vdg_data, 8'h5A);
        go(26); chk("c26_strobe", vdg_strobe, 1'b1); chk("c26_vdata", vdg_data, 8'h77);

        // blank donation: the aborted write must not have reached 0x0300
        vid_blank = 1'b1;
        req(1'b0, 14'h0300, 8'h00);
        go(28); chk("bl_a_addr", ram_addr, 14'h0300); chk("bl_a_we", ram_we, 1'b0);
        go(30); chk("bl_ack1", cpu_ack, 1'b1); chk("bl_data1", cpu_rdata, 8'h11);
        chk("bl_strobe30", vdg_strobe, 1'b0);
        cpu_req = 1'b0;
        go(31); req(1'b0, 14'h1000, 8'h00);
        go(32); chk("bl_a2_addr", ram_addr, 14'h1000);
        go(34); chk("bl_ack2", cpu_ack, 1'b1); chk("bl_data2", cpu_rdata, 8'hC3);
        chk("bl_strobe34", vdg_strobe, 1'b0); chk("bl_vdata", vdg_data, 8'h77);
        cpu_req = 1'b0;

        // handshake abuse: req held high across the ack edge, served in slot B
        go(36); req(1'b0, 14'h0200, 8'h00);
        go(38); chk("ab_b_addr", ram_addr, 14'h0200);
        go(40); chk("ab_ack", cpu_ack, 1'b1); chk("ab_data", cpu_rdata, 8'h77);
        go(41); chk("ab_ack_off", cpu_ack, 1'b0);
        cpu_req = 1'b0;
        go(42); chk("ab_no_slot", ram_addr, 14'h0000);
        go(43); chk("ab_no_ack43", cpu_ack, 1'b0);
        go(44); chk("ab_no_ack44", cpu_ack, 1'b0);
        req(1'b0, 14'h0123, 8'h00);
        go(46); chk("ab_new_addr", ram_addr, 14'h0123);
        go(47); chk("ab_new_early", cpu_ack, 1'b0);
        go(48); chk("ab_new_ack", cpu_ack, 1'b1); chk("ab_new_data", cpu_rdata, 8'h5A);
        cpu_req = 1'b0;
        go(49); chk("ab_new_off", cpu_ack, 1'b0);
        go(52); chk("ab_single", cpu_ack, 1'b0); chk("bl_vdata_end", vdg_data, 8'h77);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
